// File: rtl/ram_seq_ctrl_if.sv
// Request/response bundle between a load/store unit (master) and ram_seq_ctrl (slave).
interface ram_seq_ctrl_if;
    logic        req;
    logic        rw;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] write;
    logic [31:0] read;
    logic        ready;
    logic        exception;
    logic        busy;

    modport master (
        output req, rw, len, addr, write,
        input  read, ready, exception, busy
    );

    modport slave (
        input  req, rw, len, addr, write,
        output read, ready, exception, busy
    );
endinterface

// File: rtl/ram_seq_ctrl.sv
// Byte-serial data RAM controller: byte/half/word loads and stores, one byte per cycle.
// Optional macro RAM_MISALIGN_EN: when defined, unaligned half/word accesses are legal.
module ram_seq_ctrl #(
    parameter int unsigned RAM_WIDTH   = 10,
    parameter logic [31:0] RD_IDLE_VAL = 32'd0
) (
    input logic          clk,
    input logic          rst_n,
    ram_seq_ctrl_if.slave bus
);

    localparam int unsigned DEPTH   = 1 << RAM_WIDTH;
    localparam logic [32:0] DEPTH33 = 33'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state;
    logic [1:0]             cnt;
    logic [1:0]             last_q;
    logic                   rw_q;
    logic [RAM_WIDTH-1:0]   addr_q;
    logic [31:0]            write_q;
    logic [31:0]            read_q;
    logic                   ready_q;
    logic                   exc_q;
    logic                   busy_q;

    logic [7:0]             mem [DEPTH];
    logic [RAM_WIDTH-1:0]   mem_idx;
    logic [7:0]             mem_rdata;
    logic                   mem_we;

    // Request decode: byte count and legality of the access presented in IDLE
    logic [2:0]  req_n;
    logic [32:0] end_addr;
    logic        bad_size;
    logic        bad_range;
    logic        bad_align;
    logic        illegal;

    always_comb begin
        req_n     = 3'd1;
        bad_size  = 1'b0;
        bad_align = 1'b0;
        unique case (bus.len)
            2'b00:   req_n = 3'd1;
            2'b01:   req_n = 3'd2;
            2'b10:   req_n = 3'd4;
            default: begin
                req_n    = 3'd1;
                bad_size = 1'b1;
            end
        endcase
        // No wrap-around: the last byte must still lie inside the array
        end_addr  = {1'b0, bus.addr} + 33'(req_n) - 33'd1;
        bad_range = ((bus.addr >> RAM_WIDTH) != 32'd0) || (end_addr >= DEPTH33);
`ifdef RAM_MISALIGN_EN
        bad_align = 1'b0;
`else
        bad_align = ((bus.len == 2'b01) && bus.addr[0]) ||
                    ((bus.len == 2'b10) && (bus.addr[1:0] != 2'b00));
`endif
        illegal = bad_size || bad_range || bad_align;
    end

    // Array port: one byte per ACCESS cycle at the latched base plus byte counter
    always_comb begin
        mem_idx   = addr_q + RAM_WIDTH'(cnt);
        mem_rdata = mem[mem_idx];
        mem_we    = (state == S_ACCESS) && rw_q;
    end

    // Storage is deliberately not reset; reset only stops further writes
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= write_q[{cnt, 3'b000} +: 8];
        end
    end

    // Sequencer with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 2'd0;
            last_q  <= 2'd0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            write_q <= 32'd0;
            read_q  <= 32'd0;
            ready_q <= 1'b0;
            exc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    ready_q <= 1'b0;
                    exc_q   <= 1'b0;
                    if (bus.req) begin
                        rw_q    <= bus.rw;
                        last_q  <= 2'(req_n - 3'd1);
                        addr_q  <= bus.addr[RAM_WIDTH-1:0];
                        write_q <= bus.write;
                        cnt     <= 2'd0;
                        busy_q  <= 1'b1;
                        if (illegal) begin
                            state   <= S_DONE;
                            ready_q <= 1'b1;
                            exc_q   <= 1'b1;
                            read_q  <= RD_IDLE_VAL;
                        end else begin
                            state  <= S_ACCESS;
                            read_q <= 32'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!rw_q) begin
                        read_q[{cnt, 3'b000} +: 8] <= mem_rdata;
                    end
                    cnt <= cnt + 2'd1;
                    if (cnt == last_q) begin
                        state   <= S_DONE;
                        ready_q <= 1'b1;
                        if (rw_q) begin
                            read_q <= RD_IDLE_VAL;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                    exc_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b0;
                    exc_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.read      = read_q;
    assign bus.ready     = ready_q;
    assign bus.exception = exc_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Scoreboard bench for ram_seq_ctrl: byte-array reference model, randomized and directed accesses.
module tb_ram_seq_ctrl;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_seq_ctrl_if bus ();

    ram_seq_ctrl #(.RAM_WIDTH(AW), .RD_IDLE_VAL(32'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          exc;
        logic [31:0] data;
        int          lat;
        int          cyc0;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mdl [DEPTH];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          issued = 0;
    int          seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: legality and result computed from the access rules directly
    function automatic exp_t model(input bit rw, input logic [1:0] len,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input string name);
        exp_t e;
        int   n;
        bit   bad;
        n   = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        bad = (len == 2'd3) || (addr >= 32'(DEPTH)) ||
              (longint'(addr) + longint'(n) - 1 >= longint'(DEPTH));
`ifndef RAM_MISALIGN_EN
        if (len == 2'd1 && (addr % 2) != 0) bad = 1;
        if (len == 2'd2 && (addr % 4) != 0) bad = 1;
`endif
        e.exc  = bad;
        e.data = 32'd0;
        e.lat  = bad ? 1 : n + 1;
        e.name = name;
        e.cyc0 = cyc;
        if (!bad) begin
            for (int k = 0; k < n; k++) begin
                if (rw) mdl[int'(addr) + k] = wdata[8*k +: 8];
                else    e.data = e.data | (32'(mdl[int'(addr) + k]) << (8*k));
            end
        end
        return e;
    endfunction

    // Driver: present one request at a negedge, then hammer ignored requests until idle
    task automatic issue(input bit rw, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] wdata, input string name);
        bit finished;
        bus.req   = 1'b1;
        bus.rw    = rw;
        bus.len   = len;
        bus.addr  = addr;
        bus.write = wdata;
        exp_q.push_back(model(rw, len, addr, wdata, name));
        issued++;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_accept %s: busy=%b required 1", name, bus.busy);
        end
        finished = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy === 1'b0) begin
                finished = 1;
                break;
            end
            bus.req   = 1'($urandom);
            bus.rw    = 1'($urandom);
            bus.len   = 2'($urandom);
            bus.addr  = $urandom;
            bus.write = $urandom;
            @(negedge clk);
        end
        bus.req = 1'b0;
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL timeout %s: busy still high after 40 cycles, required low", name);
        end
    endtask

    // Monitor: pop one expectation per completion
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ready === 1'b1) begin
                seen++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_ready: ready=1 with no outstanding request, required none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checks += 3;
                    if (bus.exception !== e.exc) begin
                        failures++;
                        $display("FAIL exception %s: got %b required %b", e.name, bus.exception, e.exc);
                    end
                    if (bus.read !== e.data) begin
                        failures++;
                        $display("FAIL read %s: got %08h required %08h", e.name, bus.read, e.data);
                    end
                    if (cyc - e.cyc0 != e.lat) begin
                        failures++;
                        $display("FAIL latency %s: got %0d required %0d", e.name, cyc - e.cyc0, e.lat);
                    end
                end
            end else begin
                checks++;
                if (bus.exception !== 1'b0) begin
                    failures++;
                    $display("FAIL exception_outside_ready: got %b required 0", bus.exception);
                end
            end
        end
    end

    task automatic check_zero(input string name, input logic [31:0] got);
        checks++;
        if (got !== 32'd0) begin
            failures++;
            $display("FAIL %s: got %08h required 0", name, got);
        end
    endtask

    initial begin
        bus.req = 1'b0; bus.rw = 1'b0; bus.len = 2'd0; bus.addr = 32'd0; bus.write = 32'd0;
        repeat (3) @(negedge clk);
        check_zero("reset_read", bus.read);
        check_zero("reset_ready", 32'(bus.ready));
        check_zero("reset_exception", 32'(bus.exception));
        check_zero("reset_busy", 32'(bus.busy));
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the array so every later load has a known reference value
        for (int a = 0; a < DEPTH; a += 4) issue(1'b1, 2'd2, 32'(a), $urandom, "fill");

        issue(1'b1, 2'd2, 32'h10, 32'hDEADBEEF, "st_w_10");
        issue(1'b0, 2'd2, 32'h10, 32'h0, "ld_w_10");
        issue(1'b0, 2'd0, 32'h12, 32'h0, "ld_b_12");
        issue(1'b1, 2'd1, 32'h20, 32'h0000A55A, "st_h_20");
        issue(1'b0, 2'd1, 32'h20, 32'h0, "ld_h_20");
        issue(1'b0, 2'd2, 32'h3FE, 32'h0, "ld_w_3fe");
        issue(1'b0, 2'd2, 32'h400, 32'h0, "ld_w_400");
        issue(1'b0, 2'd0, 32'h3FF, 32'h0, "ld_b_3ff");
        issue(1'b0, 2'd0, 32'h400, 32'h0, "ld_b_400");
        issue(1'b0, 2'd0, 32'h8000_0000, 32'h0, "ld_b_hi");
        issue(1'b1, 2'd2, 32'h21, 32'hCAFEF00D, "st_w_21");
        issue(1'b0, 2'd2, 32'h21, 32'h0, "ld_w_21");
        for (int k = 0; k < 5; k++) issue(1'b0, 2'd0, 32'h21 + 32'(k), 32'h0, "ld_b_near21");
        issue(1'b1, 2'd1, 32'h31, 32'h1234, "st_h_31");
        issue(1'b0, 2'd3, 32'h0, 32'h0, "len11");
        issue(1'b1, 2'd3, 32'h8, 32'hFFFFFFFF, "st_len11");

        // Abort a word store after two bytes have been written
        bus.req = 1'b1; bus.rw = 1'b1; bus.len = 2'd2; bus.addr = 32'h40; bus.write = 32'h11223344;
        @(posedge clk);
        #1 bus.req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_zero("abort_read", bus.read);
        check_zero("abort_ready", 32'(bus.ready));
        check_zero("abort_exception", 32'(bus.exception));
        check_zero("abort_busy", 32'(bus.busy));
        mdl[32'h40] = 8'h44;
        mdl[32'h41] = 8'h33;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 2'd2, 32'h40, 32'h0, "ld_w_40_after_abort");

        // Randomized traffic, mostly in range with some edge addresses
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'(DEPTH) - 32'($urandom_range(1, 4));
                default: a = 32'($urandom_range(0, DEPTH - 1));
            endcase
            issue(1'($urandom), 2'($urandom), a, $urandom, "random");
        end

        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || seen != issued) begin
            failures++;
            $display("FAIL completion_count: ready pulses %0d outstanding %0d, required %0d and 0",
                     seen, exp_q.size(), issued);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
